// File: rtl/gamma_bank_ctrl.sv
// Double-buffered gamma LUT: the active bank maps pixels, the shadow bank takes host writes, and a commit swaps the banks at the next frame start.
// Latency: pixel path fixed at 2 cycles (RAM read, then output register); config writes take effect on the next edge.
// Backpressure: none on pixels; shadow writes issued while a commit is pending are dropped and flagged on O_cfg_drop.
module gamma_bank_ctrl #(
    parameter int DW_IN  = 8,
    parameter int DW_OUT = 12
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_vs,
    input  logic              I_de,
    input  logic [DW_IN-1:0]  I_data,
    output logic              O_vs,
    output logic              O_de,
    output logic [DW_OUT-1:0] O_data,
    input  logic              I_cfg_wr,
    input  logic [DW_IN-1:0]  I_cfg_addr,
    input  logic [DW_OUT-1:0] I_cfg_data,
    input  logic              I_cfg_commit,
    output logic              O_cfg_busy,
    output logic              O_cfg_drop,
    output logic              O_active_bank,
    output logic              O_table_valid
);

    localparam int DEPTH = 2 ** DW_IN;

    typedef enum logic [1:0] {IDLE, PENDING, SWAP} state_t;

    state_t            state;
    logic              vs_q;
    logic              fs;
    logic [DW_OUT-1:0] mem [2*DEPTH];
    logic [DW_OUT-1:0] rd_dat;
    logic              vs_d1;
    logic              de_d1;
    logic              tv_d1;
    logic [DW_IN-1:0]  pix_d1;

    assign fs = I_vs & ~vs_q;

    // Both banks share one array; the bank index is the address MSB.
    always_ff @(posedge I_clk) begin
        if (I_cfg_wr && state == IDLE)
            mem[{~O_active_bank, I_cfg_addr}] <= I_cfg_data;
        rd_dat <= mem[{O_active_bank, I_data}];
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vs_d1  <= 1'b0;
            de_d1  <= 1'b0;
            tv_d1  <= 1'b0;
            pix_d1 <= '0;
            O_vs   <= 1'b0;
            O_de   <= 1'b0;
            O_data <= '0;
        end else begin
            vs_d1  <= I_vs;
            de_d1  <= I_de;
            tv_d1  <= O_table_valid;
            pix_d1 <= I_data;
            O_vs   <= vs_d1;
            O_de   <= de_d1;
            // Table-valid travels with the pixel so the first swap never splits a pixel.
            O_data <= tv_d1 ? rd_dat : {pix_d1, {(DW_OUT-DW_IN){1'b0}}};
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state         <= IDLE;
            vs_q          <= 1'b0;
            O_cfg_busy    <= 1'b0;
            O_cfg_drop    <= 1'b0;
            O_active_bank <= 1'b0;
            O_table_valid <= 1'b0;
        end else begin
            vs_q       <= I_vs;
            O_cfg_drop <= I_cfg_wr && (state != IDLE);
            case (state)
                IDLE: begin
                    if (I_cfg_commit) begin
                        state      <= PENDING;
                        O_cfg_busy <= 1'b1;
                    end
                end
                PENDING: begin
                    if (fs)
                        state <= SWAP;
                end
                SWAP: begin
                    O_active_bank <= ~O_active_bank;
                    O_table_valid <= 1'b1;
                    O_cfg_busy    <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    O_cfg_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
